// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: FSM encoding, nibble
// correction constants and the default digit count.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_CORR_TH   = 4'd8;
  localparam logic [3:0] BCD_CORR_VAL  = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  localparam int DEF_DIGITS = 3;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_nibble_sub3.sv
// Reverse double-dabble correction cell: subtract 3 from a nibble that is 8 or
// more after the right shift, otherwise pass it through unchanged.
module bcd_nibble_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= BCD_CORR_TH) ? (i_nib - BCD_CORR_VAL) : i_nib;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per clock).
// Define BCD2BIN_CHECK_EN to flag digits above 9 on err and force bin_out to 0.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds data stable while valid is high and ready is low,
// and ready never depends combinationally on valid.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (ACC_W > 2) ? $clog2(ACC_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_bcd;
  // Only the upper ACC_W-1 accumulator bits are stored: bit 0 is always zero
  // until the final shift, whose full result goes straight into bin_out.
  logic [ACC_W-2:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin_out;
  logic               r_out_valid;

  logic [ACC_W-1:0]   w_bcd_shift;
  logic [ACC_W-1:0]   w_bcd_next;
  logic [ACC_W-1:0]   w_acc_full;
  logic [BIN_W-1:0]   w_bin;
  logic               w_bad;

  assign w_bcd_shift = {1'b0, r_bcd[ACC_W-1:1]};
  assign w_acc_full  = {r_bcd[0], r_acc};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_nibble_sub3 u_sub3 (
      .i_nib (w_bcd_shift[4*g +: 4]),
      .o_nib (w_bcd_next[4*g +: 4])
    );
  end

  if (BIN_W <= ACC_W) begin : g_bin_trunc
    assign w_bin = w_acc_full[BIN_W-1:0];
  end else begin : g_bin_ext
    assign w_bin = {{(BIN_W-ACC_W){1'b0}}, w_acc_full};
  end

`ifdef BCD2BIN_CHECK_EN
  logic r_bad;
  logic r_err;

  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_invalid(bcd_in[4*d +: 4])) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_bad <= w_bad;
    end else if (r_state == SHIFT && r_cnt == CNT_LAST) begin
      r_err <= r_bad;
    end
  end

  assign err = r_err;
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bcd       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bin_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bcd   <= bcd_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_acc <= w_acc_full[ACC_W-1:1];
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
            r_bin_out   <= r_bad ? '0 : w_bin;
`else
            r_bin_out   <= w_bin;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed table, backpressure, reset
// mid-conversion, full 0..999 sweep and random words against a decimal model.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  bin_out;
  logic        err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];  // {err, bin}

  typedef struct {
    logic [11:0] bcd;
    int          hold;
    logic [9:0]  exp_bin;
    logic        exp_err;
    bit          chk_bin;
  } vec_t;

  vec_t vecs[6];

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // decimal reference model
  task automatic model(input logic [11:0] w, output logic [9:0] b, output logic e,
                       output bit chk);
    int v;
    bit bad;
    logic [3:0] d;
    v = 0;
    bad = 0;
    for (int i = 2; i >= 0; i--) begin
      d = w[4*i +: 4];
      if (d > 4'd9) bad = 1;
      v = v * 10 + int'(d);
    end
`ifdef BCD2BIN_CHECK_EN
    e   = bad;
    b   = bad ? 10'd0 : v[9:0];
    chk = 1;
`else
    e   = 1'b0;
    b   = v[9:0];
    chk = !bad;
`endif
  endtask

  // driver: one complete conversion with optional output backpressure
  task automatic run_one(input string name, input logic [11:0] bcd, input int hold,
                         input logic [9:0] exp_bin, input logic exp_err, input bit chk_bin);
    int n;
    int lat;
    bit ir_ok;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_accept"}, in_ready, 1);
    in_valid  = 1'b1;
    bcd_in    = bcd;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat   = 1;
    ir_ok = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_in_ready_low"}, ir_ok, 1);
    check({name, "_latency"}, lat, 13);
    check({name, "_out_valid"}, out_valid, 1);
    if (chk_bin) check({name, "_bin"}, bin_out, exp_bin);
    check({name, "_err"}, err, exp_err);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      bcd_in   = 12'h777;
      @(posedge clk); #1;
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_in_ready"}, in_ready, 0);
      if (chk_bin) check({name, "_hold_bin"}, bin_out, exp_bin);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_drop_valid"}, out_valid, 0);
    check({name, "_idle"}, dbg_state, 0);
  endtask

  initial begin
    logic [11:0] w;
    logic [9:0]  mb;
    logic        me;
    bit          mc;
    logic [10:0] e;
    int          seen;

    vecs[0] = '{bcd: 12'h999, hold: 0, exp_bin: 10'd999, exp_err: 1'b0, chk_bin: 1};
    vecs[1] = '{bcd: 12'h000, hold: 0, exp_bin: 10'd0,   exp_err: 1'b0, chk_bin: 1};
    vecs[2] = '{bcd: 12'h010, hold: 1, exp_bin: 10'd10,  exp_err: 1'b0, chk_bin: 1};
    vecs[3] = '{bcd: 12'h507, hold: 2, exp_bin: 10'd507, exp_err: 1'b0, chk_bin: 1};
`ifdef BCD2BIN_CHECK_EN
    vecs[4] = '{bcd: 12'h1A3, hold: 0, exp_bin: 10'd0,   exp_err: 1'b1, chk_bin: 1};
`else
    vecs[4] = '{bcd: 12'h1A3, hold: 0, exp_bin: 10'd0,   exp_err: 1'b0, chk_bin: 0};
`endif
    vecs[5] = '{bcd: 12'h321, hold: 5, exp_bin: 10'd321, exp_err: 1'b0, chk_bin: 1};

    rst = 1'b1;
    in_valid = 1'b0;
    bcd_in = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bin", bin_out, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    foreach (vecs[i])
      run_one($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].hold, vecs[i].exp_bin,
              vecs[i].exp_err, vecs[i].chk_bin);

    // reset in the middle of a conversion discards it
    @(posedge clk); #1;
    in_valid = 1'b1;
    bcd_in   = 12'h999;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_state", dbg_state, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    run_one("after_rst", 12'h042, 0, 10'd42, 1'b0, 1);

    // exhaustive sweep with random backpressure
    for (int v = 0; v < 1000; v++) begin
      w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      exp_q.push_back({1'b0, 10'(v)});
      e = exp_q.pop_front();
      run_one($sformatf("sweep%0d", v), w, $urandom_range(0, 2), e[9:0], e[10], 1);
    end

    // random words, some with illegal digits
    for (int r = 0; r < 150; r++) begin
      for (int d = 0; d < 3; d++)
        w[4*d +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      model(w, mb, me, mc);
      exp_q.push_back({me, mb});
      e = exp_q.pop_front();
      run_one($sformatf("rand%0d", r), w, $urandom_range(0, 3), e[9:0], e[10], mc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
